// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state type and default sizing for the hazard control unit.
package hazard_pkg;
  typedef enum logic {IDLE, MDU_BUSY} state_e;
  localparam int REG_W = 4;
  localparam int CNT_W = 4;
  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 8;
endpackage

// File: rtl/stall_counter.sv
// stall_counter: loadable down-counter with zero flag; holds at zero.
module stall_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d  = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
  assign zero_o = cnt_q == '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/hazard_control.sv
// hazard_control: pipeline hold/flush generation for load-use, taken branch and multi-cycle MDU stalls.
// Optional HAZARD_STATS_EN adds saturating stall_cycles / flush_events counters.
module hazard_control
  import hazard_pkg::*;
#(
  parameter int REG_W      = hazard_pkg::REG_W,
  parameter int CNT_W      = hazard_pkg::CNT_W,
  parameter int MUL_CYCLES = hazard_pkg::MUL_CYCLES,
  parameter int DIV_CYCLES = hazard_pkg::DIV_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             branch_taken,
  input  logic             mdu_start,
  input  logic             mdu_is_div,
  output logic             pc_hold,
  output logic             hold_ifid,
  output logic             hold_idex,
  output logic             hold_exmem,
  output logic             hold_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
`ifdef HAZARD_STATS_EN
  output logic [15:0]      stall_cycles,
  output logic [15:0]      flush_events,
`endif
  output logic             mdu_done
);
  state_e state_q, state_d;
  logic cnt_zero, idle, load_use, mdu_go, busy_stall, busy_done, br_go, lu_go;
  assign idle       = state_q == IDLE;
  assign load_use   = idex_mem_read && idex_rd != '0 &&
                      (idex_rd == ifid_rs1 || (ifid_uses_rs2 && idex_rd == ifid_rs2));
  assign mdu_go     = idle && mdu_start;
  assign br_go      = idle && !mdu_start && branch_taken;
  assign lu_go      = idle && !mdu_start && !branch_taken && load_use;
  assign busy_stall = !idle && !cnt_zero;
  assign busy_done  = !idle && cnt_zero;
  // Outputs are combinational, so they are forced low for the whole reset pulse.
  assign pc_hold     = !reset && (mdu_go || busy_stall || lu_go);
  assign hold_ifid   = pc_hold;
  assign hold_idex   = !reset && (mdu_go || busy_stall);
  assign flush_exmem = hold_idex;
  assign hold_exmem  = 1'b0;
  assign hold_memwb  = 1'b0;
  assign flush_ifid  = !reset && br_go;
  assign flush_idex  = !reset && (br_go || lu_go);
  assign mdu_done    = !reset && busy_done;
  assign state_d = mdu_go ? MDU_BUSY : busy_done ? IDLE : state_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  stall_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .load_i     (mdu_go),
    .dec_i      (busy_stall),
    .load_val_i (mdu_is_div ? CNT_W'(DIV_CYCLES - 2) : CNT_W'(MUL_CYCLES - 2)),
    .zero_o     (cnt_zero)
  );
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_q, stall_d, flush_q, flush_d;
  assign stall_d = stall_q + 16'(pc_hold && stall_q != '1);
  assign flush_d = flush_q + 16'((flush_ifid || flush_idex) && flush_q != '1);
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
`endif
endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control: directed + randomized checks against a cycle-count reference model.
module tb_hazard_control;
  logic clock = 1'b0, reset = 1'b1;
  logic [3:0] ifid_rs1 = '0, ifid_rs2 = '0, idex_rd = '0;
  logic ifid_uses_rs2 = 0, idex_mem_read = 0, branch_taken = 0, mdu_start = 0, mdu_is_div = 0;
  logic pc_hold, hold_ifid, hold_idex, hold_exmem, hold_memwb, flush_ifid, flush_idex, flush_exmem, mdu_done;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles, flush_events;
`endif
  logic [7:0] obs, o;
  int compared = 0, mismatched = 0;
  int m_left = 0, m_stall = 0, m_flush = 0;
  int stalls, dones;

  always #5 clock = ~clock;

  hazard_control dut (
    .clock(clock), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .branch_taken(branch_taken),
    .mdu_start(mdu_start), .mdu_is_div(mdu_is_div),
    .pc_hold(pc_hold), .hold_ifid(hold_ifid), .hold_idex(hold_idex),
    .hold_exmem(hold_exmem), .hold_memwb(hold_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
`ifdef HAZARD_STATS_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .mdu_done(mdu_done)
  );

  assign obs = {pc_hold, hold_ifid, hold_idex, hold_exmem, hold_memwb, flush_ifid, flush_idex, flush_exmem} == '0 && !mdu_done ? 8'h00 :
               {pc_hold, hold_ifid, hold_idex, hold_memwb | hold_exmem, flush_ifid, flush_idex, flush_exmem, mdu_done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: m_left counts the remaining cycles an MDU op stays in EX after its start cycle.
  function automatic logic [7:0] model_out();
    logic lu;
    if (reset) return 8'h00;
    if (m_left > 0) return (m_left > 1) ? 8'b1110_0010 : 8'b0000_0001;
    if (mdu_start) return 8'b1110_0010;
    if (branch_taken) return 8'b0000_1100;
    lu = idex_mem_read && idex_rd != 0 &&
         (idex_rd == ifid_rs1 || (ifid_uses_rs2 && idex_rd == ifid_rs2));
    return lu ? 8'b1100_0100 : 8'h00;
  endfunction

  task automatic step(input string tag, input logic r, input logic ms, input logic dv, input logic br,
                      input logic mr, input logic u2, input logic [3:0] rd, input logic [3:0] rs1,
                      input logic [3:0] rs2, output logic [7:0] res);
    logic [7:0] e;
    reset = r; mdu_start = ms; mdu_is_div = dv; branch_taken = br;
    idex_mem_read = mr; ifid_uses_rs2 = u2; idex_rd = rd; ifid_rs1 = rs1; ifid_rs2 = rs2;
    @(negedge clock);
    e = model_out();
    res = obs;
    check(tag, obs, e);
`ifdef HAZARD_STATS_EN
    check({tag, "_stall_cycles"}, stall_cycles, m_stall);
    check({tag, "_flush_events"}, flush_events, m_flush);
`endif
    @(posedge clock);
    if (reset) begin
      m_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_stall += e[7];
      m_flush += (e[3] | e[2]);
      if (m_left > 0) m_left--;
      else if (mdu_start) m_left = (mdu_is_div ? 8 : 4) - 1;
    end
    #1;
  endtask

  task automatic run_mdu(input string tag, input logic dv, input int n);
    stalls = 0; dones = 0;
    for (int i = 0; i < n; i++) begin
      step(tag, 0, 1, dv, 0, 0, 0, 0, 0, 0, o);
      stalls += o[7];
      dones  += o[0];
    end
  endtask

  initial begin
    step("reset", 1, 1, 1, 1, 1, 1, 3, 3, 3, o);
    check("reset_all_zero", o, 0);
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, o);
    step("load_use", 0, 0, 0, 0, 1, 0, 3, 3, 0, o);
    check("load_use_outputs", o, 8'b1100_0100);
    step("load_use_clear", 0, 0, 0, 0, 0, 0, 3, 3, 0, o);
    check("load_use_clear_outputs", o, 0);
    step("load_r0", 0, 0, 0, 0, 1, 1, 0, 0, 0, o);
    check("load_r0_no_stall", o, 0);
    step("rs2_unused", 0, 0, 0, 0, 1, 0, 5, 1, 5, o);
    check("rs2_unused_no_stall", o, 0);
    step("rs2_used", 0, 0, 0, 0, 1, 1, 5, 1, 5, o);
    check("rs2_used_stall", o[7], 1);
    run_mdu("div", 1, 8);
    check("div_stall_cycles", stalls, 7);
    check("div_done_last", o[0], 1);
    step("div_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, o);
    check("div_after_idle", o, 0);
    run_mdu("mul", 0, 4);
    check("mul_stall_cycles", stalls, 3);
    check("mul_done_last", o[0], 1);
    step("mul_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, o);
    step("br_lu", 0, 0, 0, 1, 1, 0, 3, 3, 0, o);
    check("branch_beats_load_use", o, 8'b0000_1100);
    run_mdu("div_pre_rst", 1, 2);
    step("div_rst", 1, 1, 1, 0, 0, 0, 0, 0, 0, o);
    check("reset_aborts_div", o, 0);
    run_mdu("div_restart", 1, 8);
    check("div_restart_stalls", stalls, 7);
    check("div_restart_dones", dones, 1);
    step("rst2", 1, 0, 0, 0, 0, 0, 0, 0, 0, o);
    run_mdu("mul_b2b", 0, 8);
    check("mul_b2b_stalls", stalls, 6);
    check("mul_b2b_dones", dones, 2);
`ifdef HAZARD_STATS_EN
    @(negedge clock);
    check("mul_b2b_stats", stall_cycles, 6);
    @(posedge clock); #1;
`endif
    for (int i = 0; i < 3000; i++)
      step("random", $urandom_range(63) == 0, $urandom_range(9) == 0, 1'($urandom),
           $urandom_range(5) == 0, $urandom_range(2) != 0, 1'($urandom),
           4'($urandom_range(3)), 4'($urandom_range(3)), 4'($urandom_range(3)), o);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
